// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready byte input, LSB-first frame, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the i_BREAK port and a BREAK state that holds the line low on request.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_n,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_DATA,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_BREAK,
`endif
  output logic                 o_TX_READY,
  output logic                 o_SERIAL_DATA,
  output logic                 o_TX_ACTIVE,
  output logic                 o_TX_DONE
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != 0);
  localparam logic             ODD_PARITY = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , BREAK = 3'd5
`endif
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 parity_bit, parity_n;
  logic                 line, line_n;
  logic                 ready, ready_n;
  logic                 active, active_n;
  logic                 done, done_n;
  logic                 bit_end;
`ifdef UART_TX_BREAK_EN
  logic                 break_low, break_low_n;
`endif

  assign bit_end = (cnt == CNT_LAST);

  // State register and every output are registered here, so the outputs never glitch.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      line       <= 1'b1;
      ready      <= 1'b1;
      active     <= 1'b0;
      done       <= 1'b0;
`ifdef UART_TX_BREAK_EN
      break_low  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      stop_idx   <= stop_idx_n;
      shreg      <= shreg_n;
      parity_bit <= parity_n;
      line       <= line_n;
      ready      <= ready_n;
      active     <= active_n;
      done       <= done_n;
`ifdef UART_TX_BREAK_EN
      break_low  <= break_low_n;
`endif
    end
  end

  // Next-state logic computes the value each output register takes on the coming edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    parity_n   = parity_bit;
    line_n     = line;
    ready_n    = ready;
    active_n   = active;
    done_n     = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_low_n = break_low;
`endif

    case (state)
      IDLE: begin
        cnt_n      = '0;
        idx_n      = '0;
        stop_idx_n = 1'b0;
        line_n     = 1'b1;
        ready_n    = 1'b1;
        active_n   = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (i_BREAK) begin
          state_n     = BREAK;
          break_low_n = 1'b1;
          line_n      = 1'b0;
          ready_n     = 1'b0;
          active_n    = 1'b1;
        end else
`endif
        if (i_TX_DV && ready) begin
          state_n  = START;
          shreg_n  = i_TX_DATA;
          parity_n = (^i_TX_DATA) ^ ODD_PARITY;
          line_n   = 1'b0;
          ready_n  = 1'b0;
          active_n = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          line_n  = shreg[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // The shift register keeps the next data bit at position 1.
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (HAS_PARITY) begin
              state_n = PARITY;
              line_n  = parity_bit;
            end else begin
              state_n = STOP;
              line_n  = 1'b1;
            end
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg >> 1;
            line_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          line_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (stop_idx == STOP_LAST) begin
            state_n    = IDLE;
            stop_idx_n = 1'b0;
            done_n     = 1'b1;
            ready_n    = 1'b1;
            active_n   = 1'b0;
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

`ifdef UART_TX_BREAK_EN
      // Hold low while requested, then a mark of STOP_BITS periods; no done pulse.
      BREAK: begin
        if (break_low) begin
          if (!i_BREAK) begin
            break_low_n = 1'b0;
            line_n      = 1'b1;
            cnt_n       = '0;
            stop_idx_n  = 1'b0;
          end
        end else if (bit_end) begin
          cnt_n = '0;
          if (stop_idx == STOP_LAST) begin
            state_n    = IDLE;
            stop_idx_n = 1'b0;
            ready_n    = 1'b1;
            active_n   = 1'b0;
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif

      default: begin
        state_n    = IDLE;
        cnt_n      = '0;
        idx_n      = '0;
        stop_idx_n = 1'b0;
        line_n     = 1'b1;
        ready_n    = 1'b1;
        active_n   = 1'b0;
      end
    endcase
  end

  assign o_SERIAL_DATA = line;
  assign o_TX_READY    = ready;
  assign o_TX_ACTIVE   = active;
  assign o_TX_DONE     = done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (8N1, 7E1, 7O1, 8N2) at 4 clocks per bit.
// Break tests are compiled in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dv      [4];
  logic [8:0] tx_data [4];
  logic       ready   [4];
  logic       line    [4];
  logic       active  [4];
  logic       done    [4];
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_CLK(clk), .i_RESET_n(reset_n), .i_TX_DV(dv[0]), .i_TX_DATA(tx_data[0][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_BREAK(brk),
`endif
    .o_TX_READY(ready[0]), .o_SERIAL_DATA(line[0]), .o_TX_ACTIVE(active[0]), .o_TX_DONE(done[0]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
    .i_CLK(clk), .i_RESET_n(reset_n), .i_TX_DV(dv[1]), .i_TX_DATA(tx_data[1][6:0]),
`ifdef UART_TX_BREAK_EN
    .i_BREAK(1'b0),
`endif
    .o_TX_READY(ready[1]), .o_SERIAL_DATA(line[1]), .o_TX_ACTIVE(active[1]), .o_TX_DONE(done[1]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
    .i_CLK(clk), .i_RESET_n(reset_n), .i_TX_DV(dv[2]), .i_TX_DATA(tx_data[2][6:0]),
`ifdef UART_TX_BREAK_EN
    .i_BREAK(1'b0),
`endif
    .o_TX_READY(ready[2]), .o_SERIAL_DATA(line[2]), .o_TX_ACTIVE(active[2]), .o_TX_DONE(done[2]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .i_CLK(clk), .i_RESET_n(reset_n), .i_TX_DV(dv[3]), .i_TX_DATA(tx_data[3][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_BREAK(1'b0),
`endif
    .o_TX_READY(ready[3]), .o_SERIAL_DATA(line[3]), .o_TX_ACTIVE(active[3]), .o_TX_DONE(done[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [8:0] word);
    dv[inst]      = 1'b1;
    tx_data[inst] = word;
    tick();
    dv[inst]      = 1'b0;
  endtask

  // Records the line for n cycles; optionally pulses dv with new data at cycle poke_at.
  task automatic captureFrame(input int inst, input int n, input int poke_at, input logic [8:0] poke_data,
                              output logic [127:0] bits, output int done_seen);
    bits      = '0;
    done_seen = 0;
    for (int k = 0; k < n; k++) begin
      bits[k] = line[inst];
      if (done[inst]) done_seen++;
      if (k == poke_at) begin
        dv[inst]      = 1'b1;
        tx_data[inst] = poke_data;
      end else if (k == poke_at + 1) begin
        dv[inst] = 1'b0;
      end
      tick();
    end
  endtask

  // Frame bit i (start first) becomes CPB consecutive samples.
  function automatic logic [127:0] expandBits(input logic [15:0] frame, input int nbits);
    logic [127:0] r = '0;
    for (int i = 0; i < nbits * CPB; i++) r[i] = frame[i / CPB];
    return r;
  endfunction

  logic [127:0] obs;
  logic [127:0] exp_v;
  int           nd;

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv[i]      = 1'b0;
      tx_data[i] = '0;
    end
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_line",   line[0],   1);
    checkOutput("reset_ready",  ready[0],  1);
    checkOutput("reset_active", active[0], 0);
    checkOutput("reset_done",   done[0],   0);
    checkOutput("reset_line_8n2", line[3], 1);
    reset_n = 1'b1;
    tick();
    checkOutput("idle_line", line[0], 1);

    // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
    applyStimulus(0, 9'h0A5);
    checkOutput("accept_ready_low",  ready[0],  0);
    checkOutput("accept_active_high", active[0], 1);
    captureFrame(0, 40, -10, 9'h000, obs, nd);
    checkOutput("frame_8n1_a5", obs, expandBits(16'b1_10100101_0, 10));
    checkOutput("a5_no_early_done", nd, 0);
    checkOutput("a5_done_pulse",  done[0],   1);
    checkOutput("a5_ready_back",  ready[0],  1);
    checkOutput("a5_active_low",  active[0], 0);
    checkOutput("a5_line_idle",   line[0],   1);
    tick();
    checkOutput("a5_done_one_cycle", done[0], 0);

    // 7E1 and 7O1 with 0x07: XOR of data is 1
    applyStimulus(1, 9'h007);
    captureFrame(1, 40, -10, 9'h000, obs, nd);
    checkOutput("frame_7e1_07", obs, expandBits(16'b1_1_0000111_0, 10));
    checkOutput("even_parity_bit", obs[32], 1);
    checkOutput("7e1_done", done[1], 1);
    checkOutput("7e1_no_early_done", nd, 0);
    applyStimulus(2, 9'h007);
    captureFrame(2, 40, -10, 9'h000, obs, nd);
    checkOutput("frame_7o1_07", obs, expandBits(16'b1_0_0000111_0, 10));
    checkOutput("odd_parity_bit", obs[32], 0);
    checkOutput("7o1_done", done[2], 1);

    // 8N2 back-to-back with dv held high: 0x00 then 0xFF
    dv[3]      = 1'b1;
    tx_data[3] = 9'h000;
    tick();
    tx_data[3] = 9'h0FF;
    captureFrame(3, 44, -10, 9'h000, obs, nd);
    checkOutput("frame_8n2_00", obs, expandBits(16'b11_00000000_0, 11));
    checkOutput("b2b_no_early_done1", nd, 0);
    checkOutput("b2b_done1",     done[3],  1);
    checkOutput("b2b_gap_high",  line[3],  1);
    checkOutput("b2b_ready_gap", ready[3], 1);
    tick();
    dv[3] = 1'b0;
    captureFrame(3, 44, -10, 9'h000, obs, nd);
    checkOutput("frame_8n2_ff", obs, expandBits(16'b11_11111111_0, 11));
    checkOutput("b2b_no_early_done2", nd, 0);
    checkOutput("b2b_done2", done[3], 1);
    tick();
    checkOutput("b2b_no_third_line",   line[3],   1);
    checkOutput("b2b_no_third_active", active[3], 0);

    // Mid-frame request with changed data is ignored
    applyStimulus(0, 9'h03C);
    captureFrame(0, 40, 10, 9'h0FF, obs, nd);
    checkOutput("frame_ignore_3c", obs, expandBits(16'b1_00111100_0, 10));
    checkOutput("ignore_no_early_done", nd, 0);
    checkOutput("ignore_done", done[0], 1);
    tick();
    captureFrame(0, 8, -10, 9'h000, obs, nd);
    checkOutput("ignore_idle_after", obs, 128'hFF);
    checkOutput("ignore_single_done", nd, 0);

    // Reset during data bit 3 of 0x96 (bit 3 = 0)
    applyStimulus(0, 9'h096);
    captureFrame(0, 18, -10, 9'h000, obs, nd);
    exp_v = expandBits(16'b1_10010110_0, 10);
    checkOutput("pre_reset_frame", 128'(obs[17:0]), 128'(exp_v[17:0]));
    checkOutput("bit3_low", line[0], 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_line",   line[0],   1);
    checkOutput("async_reset_active", active[0], 0);
    checkOutput("async_reset_ready",  ready[0],  1);
    checkOutput("async_reset_done",   done[0],   0);
    tick();
    tick();
    checkOutput("reset_hold_done", done[0], 0);
    reset_n = 1'b1;
    tick();
    checkOutput("post_reset_done", done[0], 0);
    checkOutput("post_reset_line", line[0], 1);
    applyStimulus(0, 9'h05A);
    captureFrame(0, 40, -10, 9'h000, obs, nd);
    checkOutput("frame_after_reset_5a", obs, expandBits(16'b1_01011010_0, 10));
    checkOutput("after_reset_done", done[0], 1);

`ifdef UART_TX_BREAK_EN
    tick();
    // Break for 50 cycles from IDLE, then 4-cycle mark
    brk = 1'b1;
    tick();
    obs = '0;
    nd  = 0;
    for (int k = 0; k < 54; k++) begin
      obs[k] = line[0];
      if (done[0]) nd++;
      if (k == 49) brk = 1'b0;
      if (k == 53) checkOutput("mark_ready_low", ready[0], 0);
      tick();
    end
    checkOutput("break_line_pattern", obs, {74'h0, 4'hF, 50'h0});
    checkOutput("break_no_done", nd, 0);
    checkOutput("break_ready_back", ready[0], 1);
    checkOutput("break_active_low", active[0], 0);

    // Break raised mid-frame waits for the frame to finish
    applyStimulus(0, 9'h055);
    brk = 1'b1;
    captureFrame(0, 40, -10, 9'h000, obs, nd);
    checkOutput("frame_before_break_55", obs, expandBits(16'b1_01010101_0, 10));
    checkOutput("frame_before_break_done", done[0], 1);
    tick();
    checkOutput("break_after_frame_line",   line[0],   0);
    checkOutput("break_after_frame_active", active[0], 1);
    checkOutput("break_after_frame_ready",  ready[0],  0);
    checkOutput("break_after_frame_done",   done[0],   0);
    brk = 1'b0;
    tick();
    checkOutput("mark_line_high", line[0], 1);
    tick();
    tick();
    tick();
    checkOutput("mark_end_ready_low", ready[0], 0);
    tick();
    checkOutput("mark_end_ready_high", ready[0], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
